decimal_accumulator: RTL



---
 rtl/decimal_acc_pkg.sv | 18 +
 rtl/mul10_add.sv | 22 ++
 rtl/decimal_accumulator.sv | 97 +++++++++
 3 files changed

// File: rtl/decimal_acc_pkg.sv
// Shared types and constants for the decimal accumulator datapath.
package decimal_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   localparam int DIGIT_W = 4;
   localparam int RADIX   = 10;
   localparam int MAX_BCD = 9;

   // Width needed to hold acc*10 + digit without losing carries.
   function automatic int ext_width(input int width);
      return width + DIGIT_W;
   endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational times-ten-plus-digit using two shifts and an adder chain.
module mul10_add
   import decimal_acc_pkg::*;
#(
   parameter int WIDTH = 13
) (
   input  logic [WIDTH-1:0]            x,
   input  logic [DIGIT_W-1:0]          d,
   output logic [ext_width(WIDTH)-1:0] y
);

   localparam int EW = ext_width(WIDTH);

   logic [EW-1:0] xext;

   // x*8 + x*2 + d, computed at full extended width so no carry is lost.
   always_comb begin
      xext = EW'(x);
      y    = (xext << 3) + (xext << 1) + EW'(d);
   end

endmodule

// File: rtl/decimal_accumulator.sv
// Sequential BCD-to-binary accumulator with a valid/ready digit input and a
// held result output. Optional build macro: DECIMAL_ACC_SATURATE_EN clamps the
// accumulator at 2^WIDTH-1 on overflow instead of wrapping.
module decimal_accumulator
   import decimal_acc_pkg::*;
#(
   parameter int WIDTH      = 13,
   parameter int MAX_DIGITS = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             clear,
   input  logic                             digit_valid,
   input  logic [DIGIT_W-1:0]               digit,
   input  logic                             digit_last,
   output logic                             digit_ready,
   output logic                             value_valid,
   input  logic                             value_ready,
   output logic [WIDTH-1:0]                 value,
   output logic                             overflow,
   output logic                             bad_digit,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count
);

   localparam int EW = ext_width(WIDTH);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   acc_state_t       state;
   logic [WIDTH-1:0] acc;
   logic [EW-1:0]    prod;
   logic             prod_ovf;

   mul10_add #(.WIDTH(WIDTH)) u_mul10_add (
      .x (acc),
      .d (digit),
      .y (prod)
   );

   // Any nonzero bit above WIDTH means the new value no longer fits.
   always_comb begin
      prod_ovf = |prod[EW-1:WIDTH];
   end

   // Handshake outputs decode straight from the state register.
   always_comb begin
      digit_ready = (state == ACCUM);
      value_valid = (state == HOLD);
      value       = acc;
   end

   // Main FSM: accumulate digits, freeze on the last one, release on value_ready.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state       <= ACCUM;
         acc         <= '0;
         digit_count <= '0;
         overflow    <= 1'b0;
         bad_digit   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (digit_valid) begin
                  if (digit > DIGIT_W'(MAX_BCD)) begin
                     bad_digit <= 1'b1;
                  end else if (digit_count == CW'(MAX_DIGITS)) begin
                     overflow <= 1'b1;
                  end else begin
                     if (prod_ovf) begin
                        overflow <= 1'b1;
                     end
`ifdef DECIMAL_ACC_SATURATE_EN
                     acc <= prod_ovf ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
`else
                     acc <= prod[WIDTH-1:0];
`endif
                     digit_count <= digit_count + CW'(1);
                  end
                  if (digit_last) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (value_ready) begin
                  state       <= ACCUM;
                  acc         <= '0;
                  digit_count <= '0;
                  overflow    <= 1'b0;
                  bad_digit   <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
